sha3_msg_sequencer: RTL and testbench
=====================================

# sha3_msg_sequencer

Sequencer and arbiter in front of the SHA3 core (Keccak-512, 64-bit word input, 512-bit digest). It shares the single core between `N_REQ` message sources with round-robin arbitration and forwards one whole message at a time as 64-bit words. It generates the core's `is_last`/`byte_num` framing, including the extra empty final word for 8-byte-aligned messages. It captures the digest, returns it tagged with the requester id, and pulses the core's synchronous reset between messages because the core's `out_ready` only clears on reset.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters (≥2).
- `ID_W`, default `$clog2(N_REQ)`: requester id width.

Ports:
- `clk`  in  1  — single clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  N_REQ  — requester i presents a word.
- `req_data`  in  64·N_REQ  — word from requester i, slice [64i+63:64i].
- `req_last`  in  N_REQ  — word is the final word of the message.
- `req_bytes`  in  3·N_REQ  — valid bytes in the final word: 1..7, with 0 meaning 8. Ignored when `req_last`=0.
- `req_ready`  out  N_REQ  — sequencer accepts the word from requester i.
- `dig_valid`  out  1  — digest available.
- `dig_data`  out  512  — digest.
- `dig_id`  out  ID_W  — requester that owns the digest.
- `dig_ready`  in  1  — digest consumer accepts.
- `core_in`  out  64  — to core `in`.
- `core_in_ready`  out  1  — to core `in_ready`; one pulse per word.
- `core_is_last`  out  1  — to core `is_last`.
- `core_byte_num`  out  3  — to core `byte_num`.
- `core_reset`  out  1  — to core `reset`; active-high, synchronous in the core.
- `core_buffer_full`  in  1  — from core.
- `core_out`  in  512  — from core.
- `core_out_ready`  in  1  — from core.
- `busy`  out  1  — high in any state other than IDLE.

## Operation
- States: CLR, IDLE, FEED, PAD, WAIT, DONE.
- **CLR**
  - `core_reset`=1 for exactly one cycle, then go to IDLE.
  - This is the state entered on reset release.
- **IDLE**
  - If any `req_valid` is high, the round-robin arbiter picks grant g. Priority starts at (last grant + 1) mod `N_REQ`; after reset the last grant is `N_REQ`-1, so requester 0 wins first.
  - Latch g, then go to FEED.
- **FEED**
  - `req_ready[g]` = `!core_buffer_full`. All other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[g]` and `req_ready[g]` are both high. On a transfer, `core_in_ready`=1 and `core_in`=`req_data[g]` in the same cycle (combinational pass-through).
  - Non-last word: `core_is_last`=0, `core_byte_num`=0.
  - Last word with `req_bytes` 1..7: `core_is_last`=1, `core_byte_num`=`req_bytes`, then go to WAIT.
  - Last word with `req_bytes`=0 (8 bytes): forwarded with `core_is_last`=0, then go to PAD.
  - If `req_valid[g]` drops mid-message, stay in FEED indefinitely. There is no timeout.
- **PAD**
  - When `!core_buffer_full`: pulse `core_in_ready` with `core_in`=0, `core_is_last`=1, `core_byte_num`=0, then go to WAIT.
- **WAIT**
  - When `core_out_ready`=1: register `core_out` into `dig_data` and g into `dig_id`, then go to DONE.
- **DONE**
  - `dig_valid`=1, with `dig_data` and `dig_id` held stable.
  - On `dig_ready`=1, update the last grant to g and go to CLR.
- `core_out_ready` is ignored outside WAIT.
- Zero-length messages are not supported; every message carries at least one byte.

## Timing
- Reset values (while `reset_n`=0): state CLR, `core_reset`=1, `req_ready`=0, `core_in_ready`=0, `core_in`=0, `core_is_last`=0, `core_byte_num`=0, `dig_valid`=0, `dig_data`=0, `dig_id`=0, `busy`=1.
- An asynchronous reset asserted in any state aborts the message and drops any pending digest.
- Latencies:
  - Grant: 1 cycle after IDLE sees `req_valid`.
  - Words: up to one per cycle in FEED.
  - Digest: `dig_valid` rises the cycle after WAIT samples `core_out_ready`.
  - After the `dig_ready` handshake: one CLR cycle, then IDLE. The next grant therefore takes effect ≥2 cycles later.
- `core_buffer_full` is registered in the core, so the combinational `req_ready` has no loop.
- `core_in_ready` is never high while `core_buffer_full`=1.
- While `dig_ready`=0 in DONE, `dig_valid`, `dig_data` and `dig_id` stay constant and no new grant is issued.

## Structure
- Package `sha3_seq_pkg`:
  - state enum
  - `WORD_W`=64, `DIGEST_W`=512, `BYTE_W`=3
  - `BYTES_FULL`=3'd0
- Sub-module `sha3_rr_arbiter`: `N_REQ` request vector plus last-grant pointer in, one-hot grant and id out, purely combinational.
- FSM, datapath mux and digest register stay in `sha3_msg_sequencer`.

## Test plan
- **Unaligned message.** Req0 sends 3 words, last with `req_bytes`=5.
  - Required: 3 `core_in_ready` pulses; third has `core_is_last`=1, `core_byte_num`=5.
  - Required: `dig_valid` with `dig_id`=0 and the reference Keccak-512 digest; one-cycle `core_reset` after `dig_ready`.
- **Aligned message.** Req1 sends a 16-byte message, last with `req_bytes`=0.
  - Required: two full words with `core_is_last`=0, then a PAD word with `core_in`=0, `core_is_last`=1, `core_byte_num`=0.
- **Round-robin alternation.** Both requesters hold `req_valid` continuously after reset with single-word messages.
  - Required: grants in order 0,1,0,1; `dig_id` sequence matches.
- **Backpressure from core.** `core_buffer_full`=1 for 4 cycles mid-message.
  - Required: `req_ready`=0 and `core_in_ready`=0 throughout; resumed words arrive unchanged and in order.
- **Digest held.** `dig_ready`=0 for 10 cycles in DONE while req1 is valid.
  - Required: digest outputs stable; `req_ready[1]`=0 until after the handshake and CLR cycle.
- **Reset mid-message.** `reset_n` pulsed low during FEED.
  - Required: all outputs immediately take their reset values, `core_reset`=1.
  - Required: after release, one CLR cycle, then a fresh grant to requester 0.

Source files
------------

// File: rtl/sha3_seq_pkg.sv
// Shared types and constants for the SHA3 message sequencer.
package sha3_seq_pkg;

    typedef enum logic [2:0] {
        StClr,
        StIdle,
        StFeed,
        StPad,
        StWait,
        StDone
    } state_e;

    localparam int unsigned WORD_W   = 64;
    localparam int unsigned DIGEST_W = 512;
    localparam int unsigned BYTE_W   = 3;

    localparam logic [BYTE_W-1:0] BYTES_FULL = 3'd0;

endpackage

// File: rtl/sha3_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts one past the last grant.
module sha3_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o
);

    logic found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        // Walk offsets 1..N from the last grant; the first active request wins.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && req_i[i] && ((32'(last_i) + k) % N_REQ == i)) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    gnt_id_o = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sha3_msg_sequencer.sv
// Shares one Keccak-512 core between N_REQ message sources, frames words and returns
// the tagged digest, resetting the core between messages.
module sha3_msg_sequencer
    import sha3_seq_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [WORD_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [BYTE_W*N_REQ-1:0]   req_bytes,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      dig_valid,
    output logic [DIGEST_W-1:0]       dig_data,
    output logic [ID_W-1:0]           dig_id,
    input  logic                      dig_ready,
    output logic [WORD_W-1:0]         core_in,
    output logic                      core_in_ready,
    output logic                      core_is_last,
    output logic [BYTE_W-1:0]         core_byte_num,
    output logic                      core_reset,
    input  logic                      core_buffer_full,
    input  logic [DIGEST_W-1:0]       core_out,
    input  logic                      core_out_ready,
    output logic                      busy
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       gnt_q, gnt_d;
    logic [N_REQ-1:0]      gnt_oh_q, gnt_oh_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic [DIGEST_W-1:0]   dig_data_q, dig_data_d;
    logic [ID_W-1:0]       dig_id_q, dig_id_d;

    logic [N_REQ-1:0]      arb_gnt;
    logic [ID_W-1:0]       arb_id;

    logic                  sel_valid;
    logic                  sel_last;
    logic [WORD_W-1:0]     sel_data;
    logic [BYTE_W-1:0]     sel_bytes;

    sha3_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i    (req_valid),
        .last_i   (last_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_bytes = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh_q[i]) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*WORD_W +: WORD_W];
                sel_bytes = req_bytes[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_oh_d      = gnt_oh_q;
        last_d        = last_q;
        dig_data_d    = dig_data_q;
        dig_id_d      = dig_id_q;
        req_ready     = '0;
        core_in       = '0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        core_reset    = 1'b0;

        unique case (state_q)
            StClr: begin
                core_reset = 1'b1;
                state_d    = StIdle;
            end
            StIdle: begin
                if (|req_valid) begin
                    gnt_d    = arb_id;
                    gnt_oh_d = arb_gnt;
                    state_d  = StFeed;
                end
            end
            StFeed: begin
                req_ready = core_buffer_full ? '0 : gnt_oh_q;
                if (sel_valid && !core_buffer_full) begin
                    core_in_ready = 1'b1;
                    core_in       = sel_data;
                    if (sel_last) begin
                        // A full final word needs a trailing empty word to carry is_last.
                        if (sel_bytes == BYTES_FULL) begin
                            state_d = StPad;
                        end else begin
                            core_is_last  = 1'b1;
                            core_byte_num = sel_bytes;
                            state_d       = StWait;
                        end
                    end
                end
            end
            StPad: begin
                if (!core_buffer_full) begin
                    core_in_ready = 1'b1;
                    core_is_last  = 1'b1;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (core_out_ready) begin
                    dig_data_d = core_out;
                    dig_id_d   = gnt_q;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (dig_ready) begin
                    last_d  = gnt_q;
                    state_d = StClr;
                end
            end
            default: state_d = StClr;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StClr;
            gnt_q      <= '0;
            gnt_oh_q   <= '0;
            last_q     <= ID_W'(N_REQ - 1);
            dig_data_q <= '0;
            dig_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_oh_q   <= gnt_oh_d;
            last_q     <= last_d;
            dig_data_q <= dig_data_d;
            dig_id_q   <= dig_id_d;
        end
    end

    assign dig_valid = (state_q == StDone);
    assign dig_data  = dig_data_q;
    assign dig_id    = dig_id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sha3_msg_sequencer.sv
// Bench: randomized sources and core stand-in, checked against a message-level model.
module tb_sha3_msg_sequencer;

    localparam int N   = 2;
    localparam int IDW = 1;

    localparam int M_CLR  = 0;
    localparam int M_IDLE = 1;
    localparam int M_FEED = 2;
    localparam int M_WAIT = 3;
    localparam int M_DONE = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [64*N-1:0]   req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [3*N-1:0]    req_bytes = '0;
    logic [N-1:0]      req_ready;
    logic              dig_valid;
    logic [511:0]      dig_data;
    logic [IDW-1:0]    dig_id;
    logic              dig_ready = 1'b0;
    logic [63:0]       core_in;
    logic              core_in_ready;
    logic              core_is_last;
    logic [2:0]        core_byte_num;
    logic              core_reset;
    logic              core_buffer_full = 1'b0;
    logic [511:0]      core_out = '0;
    logic              core_out_ready = 1'b0;
    logic              busy;

    sha3_msg_sequencer #(
        .N_REQ (N),
        .ID_W  (IDW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_bytes        (req_bytes),
        .req_ready        (req_ready),
        .dig_valid        (dig_valid),
        .dig_data         (dig_data),
        .dig_id           (dig_id),
        .dig_ready        (dig_ready),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_reset       (core_reset),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [2:0]  b;
    } word_t;

    // Source state and stimulus knobs
    logic [63:0]  src_w [N][8];
    int           src_len [N];
    int           src_idx [N];
    int           src_gap [N];
    logic [2:0]   src_b [N];
    bit           src_act [N];
    bit           auto_new [N];
    int           p_gap = 0, p_full = 0, p_out = 100, p_dig = 100, full_cnt = 0;
    int           t_len = 1;
    logic [2:0]   t_b = 3'd1;
    bit           rand_msgs = 1'b0, rand_out = 1'b0;
    logic [511:0] out_val = '0;

    int vectors = 0;
    int miscompares = 0;

    word_t exp_q[$];
    word_t core_log[$];
    int    dig_log[$];

    int           m_mode = M_CLR;
    int           m_owner = 0;
    int           m_last = N - 1;
    int           m_src_left = 0;
    logic [511:0] m_dig = '0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    function automatic word_t log_at(input int i);
        if (i < core_log.size()) return core_log[i];
        return '1;
    endfunction

    function automatic int dig_at(input int i);
        if (i < dig_log.size()) return dig_log[i];
        return -1;
    endfunction

    // Expected core word stream for a freshly granted message.
    task automatic load_msg(input int o);
        exp_q.delete();
        for (int k = 0; k < src_len[o]; k++) begin
            if (k < src_len[o] - 1) begin
                exp_q.push_back({src_w[o][k], 1'b0, 3'd0});
            end else if (src_b[o] != 3'd0) begin
                exp_q.push_back({src_w[o][k], 1'b1, src_b[o]});
            end else begin
                exp_q.push_back({src_w[o][k], 1'b0, 3'd0});
                exp_q.push_back({64'd0, 1'b1, 3'd0});
            end
        end
        m_src_left = src_len[o];
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_core_reset"}, core_reset, 1);
        check({pfx, "_req_ready"}, req_ready, 0);
        check({pfx, "_in_ready"}, core_in_ready, 0);
        check({pfx, "_core_in"}, core_in, 0);
        check({pfx, "_is_last"}, core_is_last, 0);
        check({pfx, "_byte_num"}, core_byte_num, 0);
        check({pfx, "_dig_valid"}, dig_valid, 0);
        check({pfx, "_dig_data"}, dig_data, 0);
        check({pfx, "_dig_id"}, dig_id, 0);
        check({pfx, "_busy"}, busy, 1);
    endtask

    // Compare process: model of the sequencer's observable behaviour, one step per cycle.
    initial begin
        logic [N-1:0] exp_rr;
        logic         exp_x;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check_reset_vals("rst");
                m_mode = M_CLR;
                m_last = N - 1;
                exp_q.delete();
            end else begin
                if (core_in_ready) core_log.push_back({core_in, core_is_last, core_byte_num});
                if (dig_valid && dig_ready) dig_log.push_back(int'(dig_id));
                case (m_mode)
                    M_CLR: begin
                        check("clr_core_reset", core_reset, 1);
                        check("clr_busy", busy, 1);
                        check("clr_req_ready", req_ready, 0);
                        check("clr_in_ready", core_in_ready, 0);
                        check("clr_dig_valid", dig_valid, 0);
                        m_mode = M_IDLE;
                    end
                    M_IDLE: begin
                        check("idle_core_reset", core_reset, 0);
                        check("idle_busy", busy, 0);
                        check("idle_req_ready", req_ready, 0);
                        check("idle_in_ready", core_in_ready, 0);
                        check("idle_dig_valid", dig_valid, 0);
                        if (req_valid != '0) begin
                            m_owner = rr_pick(req_valid, m_last);
                            load_msg(m_owner);
                            m_mode = M_FEED;
                        end
                    end
                    M_FEED: begin
                        exp_rr = '0;
                        if (m_src_left > 0 && !core_buffer_full) exp_rr[m_owner] = 1'b1;
                        exp_x = (m_src_left > 0) ? (req_valid[m_owner] && !core_buffer_full)
                                                 : !core_buffer_full;
                        check("feed_req_ready", req_ready, exp_rr);
                        check("feed_in_ready", core_in_ready, exp_x);
                        check("feed_busy", busy, 1);
                        check("feed_core_reset", core_reset, 0);
                        check("feed_dig_valid", dig_valid, 0);
                        if (exp_x) begin
                            check("feed_word", {core_in, core_is_last, core_byte_num}, exp_q[0]);
                            void'(exp_q.pop_front());
                            if (m_src_left > 0) m_src_left--;
                            if (exp_q.size() == 0) m_mode = M_WAIT;
                        end
                    end
                    M_WAIT: begin
                        check("wait_in_ready", core_in_ready, 0);
                        check("wait_req_ready", req_ready, 0);
                        check("wait_dig_valid", dig_valid, 0);
                        check("wait_busy", busy, 1);
                        if (core_out_ready) begin
                            m_dig  = core_out;
                            m_mode = M_DONE;
                        end
                    end
                    default: begin
                        check("done_dig_valid", dig_valid, 1);
                        check("done_dig_data", dig_data, m_dig);
                        check("done_dig_id", dig_id, m_owner);
                        check("done_req_ready", req_ready, 0);
                        check("done_in_ready", core_in_ready, 0);
                        check("done_busy", busy, 1);
                        if (dig_ready) begin
                            m_last = m_owner;
                            m_mode = M_CLR;
                        end
                    end
                endcase
            end
        end
    end

    task automatic set_msg(input int i, input int len, input logic [2:0] b,
                           input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
        src_w[i][0] = w0;
        src_w[i][1] = w1;
        src_w[i][2] = w2;
        src_len[i]  = len;
        src_b[i]    = b;
        src_idx[i]  = 0;
        src_act[i]  = 1'b1;
    endtask

    task automatic new_msg(input int i);
        src_len[i] = rand_msgs ? int'($urandom_range(1, 4)) : t_len;
        src_b[i]   = rand_msgs ? 3'($urandom) : t_b;
        for (int k = 0; k < 8; k++) src_w[i][k] = {$urandom, $urandom};
        src_idx[i] = 0;
        src_act[i] = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = src_act[i] && (int'($urandom_range(0, 99)) >= p_gap);
            req_data[i*64 +: 64] = src_act[i] ? src_w[i][src_idx[i]] : {$urandom, $urandom};
            req_last[i] = src_act[i] && (src_idx[i] == src_len[i] - 1);
            req_bytes[i*3 +: 3] = req_last[i] ? src_b[i] : 3'($urandom);
        end
        if (full_cnt > 0) begin
            core_buffer_full = 1'b1;
            full_cnt--;
        end else begin
            core_buffer_full = int'($urandom_range(0, 99)) < p_full;
        end
        core_out_ready = int'($urandom_range(0, 99)) < p_out;
        if (rand_out) begin
            for (int k = 0; k < 16; k++) core_out[k*32 +: 32] = $urandom;
        end else begin
            core_out = out_val;
        end
        dig_ready = int'($urandom_range(0, 99)) < p_dig;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                src_idx[i]++;
                if (src_idx[i] >= src_len[i]) begin
                    src_act[i] = 1'b0;
                    src_gap[i] = rand_msgs ? int'($urandom_range(0, 5)) : 0;
                end
            end else if (!src_act[i] && auto_new[i]) begin
                if (src_gap[i] > 0) src_gap[i]--;
                else new_msg(i);
            end
        end
        drive();
    endtask

    task automatic reset_on();
        reset_n  = 1'b0;
        full_cnt = 0;
        for (int i = 0; i < N; i++) begin
            src_act[i]  = 1'b0;
            auto_new[i] = 1'b0;
            src_gap[i]  = 0;
        end
        core_log.delete();
        dig_log.delete();
        drive();
        step();
        step();
    endtask

    task automatic reset_off();
        drive();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            src_len[i] = 1;
            src_idx[i] = 0;
            src_b[i]   = 3'd0;
            src_act[i] = 1'b0;
            auto_new[i] = 1'b0;
            src_gap[i] = 0;
            for (int k = 0; k < 8; k++) src_w[i][k] = '0;
        end
        @(posedge clk);
        #1;

        // Round-robin alternation with both requesters always pending
        reset_on();
        rand_msgs = 1'b0; rand_out = 1'b0; t_len = 1; t_b = 3'd3;
        p_gap = 0; p_full = 0; p_out = 100; p_dig = 100;
        out_val = {8{64'h0123_4567_89ab_cdef}};
        auto_new[0] = 1'b1; auto_new[1] = 1'b1;
        new_msg(0); new_msg(1);
        reset_off();
        for (int k = 0; k < 200 && dig_log.size() < 4; k++) step();
        check("rr_count", dig_log.size() >= 4, 1);
        check("rr_id0", dig_at(0), 0);
        check("rr_id1", dig_at(1), 1);
        check("rr_id2", dig_at(2), 0);
        check("rr_id3", dig_at(3), 1);

        // Aligned 16-byte message from requester 1
        reset_on();
        set_msg(1, 2, 3'd0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'd0);
        reset_off();
        for (int k = 0; k < 100 && dig_log.size() < 1; k++) step();
        check("al_words", core_log.size(), 3);
        check("al_w0", log_at(0), {64'h1111_2222_3333_4444, 1'b0, 3'd0});
        check("al_w1", log_at(1), {64'h5555_6666_7777_8888, 1'b0, 3'd0});
        check("al_pad", log_at(2), {64'd0, 1'b1, 3'd0});
        check("al_id", dig_at(0), 1);

        // Unaligned message with core backpressure, then a held digest
        reset_on();
        p_dig = 0;
        out_val = {16{32'hdead_beef}};
        set_msg(0, 3, 3'd5, 64'haaaa_0000_0000_0001, 64'haaaa_0000_0000_0002,
                64'haaaa_0000_0000_0003);
        reset_off();
        for (int k = 0; k < 50 && core_log.size() < 1; k++) step();
        full_cnt = 4;
        drive();
        repeat (3) step();
        check("bp_stalled", core_log.size(), 1);
        for (int k = 0; k < 100 && !dig_valid; k++) step();
        check("hold_dig_id", dig_id, 0);
        check("hold_dig_data", dig_data, {16{32'hdead_beef}});
        set_msg(1, 1, 3'd2, 64'hbbbb_0000_0000_0004, 64'd0, 64'd0);
        drive();
        repeat (10) step();
        check("hold_dig_valid", dig_valid, 1);
        check("hold_req_ready1", req_ready[1], 0);
        p_dig = 100;
        drive();
        for (int k = 0; k < 100 && dig_log.size() < 2; k++) step();
        check("ua_w0", log_at(0), {64'haaaa_0000_0000_0001, 1'b0, 3'd0});
        check("ua_w1", log_at(1), {64'haaaa_0000_0000_0002, 1'b0, 3'd0});
        check("ua_w2", log_at(2), {64'haaaa_0000_0000_0003, 1'b1, 3'd5});
        check("ua_next", log_at(3), {64'hbbbb_0000_0000_0004, 1'b1, 3'd2});
        check("ua_ids", {dig_at(0), dig_at(1)}, {32'd0, 32'd1});

        // Asynchronous reset in the middle of a message
        reset_on();
        set_msg(1, 3, 3'd1, 64'hcccc_0001, 64'hcccc_0002, 64'hcccc_0003);
        reset_off();
        for (int k = 0; k < 50 && core_log.size() < 1; k++) step();
        check("ar_in_feed", busy && !dig_valid && core_log.size() == 1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        for (int i = 0; i < N; i++) src_act[i] = 1'b0;
        core_log.delete();
        dig_log.delete();
        set_msg(0, 1, 3'd4, 64'hdddd_0000_0000_0000, 64'd0, 64'd0);
        set_msg(1, 1, 3'd4, 64'heeee_0000_0000_0000, 64'd0, 64'd0);
        drive();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 100 && dig_log.size() < 1; k++) step();
        check("ar_first_id", dig_at(0), 0);
        check("ar_first_word", log_at(0), {64'hdddd_0000_0000_0000, 1'b1, 3'd4});

        // Long randomized run
        reset_on();
        rand_msgs = 1'b1; rand_out = 1'b1;
        p_gap = 20; p_full = 25; p_out = 30; p_dig = 50;
        auto_new[0] = 1'b1; auto_new[1] = 1'b1;
        new_msg(0); new_msg(1);
        reset_off();
        repeat (3000) step();
        check("rand_progress", dig_log.size() > 10, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
